// File: rtl/gpio_bank_pkg.sv
// Shared constants, bus payload type and byte-lane helpers for gpio_bank.
package gpio_bank_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned BE_W   = BUS_W / 8;

    localparam logic [ADDR_W-1:0] REG_IN   = 3'd0;
    localparam logic [ADDR_W-1:0] REG_OUT  = 3'd1;
    localparam logic [ADDR_W-1:0] REG_IE   = 3'd2;
    localparam logic [ADDR_W-1:0] REG_IP   = 3'd3;
    localparam logic [ADDR_W-1:0] REG_RISE = 3'd4;
    localparam logic [ADDR_W-1:0] REG_FALL = 3'd5;
    localparam logic [ADDR_W-1:0] REG_CTRL = 3'd6;
    localparam logic [ADDR_W-1:0] REG_RSVD = 3'd7;

    localparam int unsigned CTRL_IRQ_EN_BIT = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BUS_W-1:0]  data;
        logic [BE_W-1:0]   be;
    } bus_req_t;

    // Expand byte enables into a bit mask.
    function automatic logic [BUS_W-1:0] lane_mask(input logic [BE_W-1:0] be);
        logic [BUS_W-1:0] m;
        m = '0;
        for (int k = 0; k < int'(BE_W); k++) begin
            m[k*8 +: 8] = {8{be[k]}};
        end
        return m;
    endfunction

    // Replace only the enabled byte lanes of old with din.
    function automatic logic [BUS_W-1:0] merge_bytes(input logic [BUS_W-1:0] old,
                                                     input logic [BUS_W-1:0] din,
                                                     input logic [BE_W-1:0]  be);
        logic [BUS_W-1:0] m;
        m = lane_mask(be);
        return (old & ~m) | (din & m);
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Per-pin debounce filter: tap shift register sampled on a shared tick.
// Compiled only when GPIO_BANK_DEBOUNCE_EN is defined.
`ifdef GPIO_BANK_DEBOUNCE_EN
module gpio_debounce #(
    parameter int unsigned DB_TAPS = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic tick,
    input  logic din,
    output logic filt
);

    logic [DB_TAPS-1:0] taps_q;

    // Shift the synchronised sample in on every prescaler tick.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            taps_q <= '0;
        end else if (tick) begin
            taps_q <= {taps_q[DB_TAPS-2:0], din};
        end
    end

    // Accept a new level only once every tap agrees.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            filt <= 1'b0;
        end else if (&taps_q) begin
            filt <= 1'b1;
        end else if (~|taps_q) begin
            filt <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/gpio_bank.sv
// GPIO register bank: debounced inputs, byte-writable outputs, edge interrupts.
// Optional input debounce filter enabled by defining GPIO_BANK_DEBOUNCE_EN.
module gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = 16,
    parameter int unsigned OUT_WIDTH  = 32,
    parameter int unsigned DB_TAPS    = 4,
    parameter int unsigned PRESC_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [BUS_W-1:0]      din,
    input  logic [BE_W-1:0]       we,
    output logic [BUS_W-1:0]      dout,
    input  logic [IN_WIDTH-1:0]   gpio_in,
    output logic [OUT_WIDTH-1:0]  gpio_out,
    output logic                  irq
);

    // Reject out-of-range configurations at elaboration.
    if (IN_WIDTH < 1 || IN_WIDTH > BUS_W || OUT_WIDTH < 1 || OUT_WIDTH > BUS_W ||
        DB_TAPS < 2 || DB_TAPS > 8 || PRESC_BITS < 1) begin : g_bad_cfg
        $error("gpio_bank: parameter out of range");
    end

    bus_req_t              req_c;
    logic [IN_WIDTH-1:0]   sync1_q, sync2_q, filt, prev_q;
    logic [IN_WIDTH-1:0]   ie_q, ip_q, rise_en_q, fall_en_q;
    logic                  ctrl_q;
    logic [IN_WIDTH-1:0]   rise_c, fall_c, ip_set_c, ip_clr_c;
    logic [BUS_W-1:0]      rdata_c;

    assign req_c = '{addr: addr, data: din, be: we};

    // Two-flop synchroniser on the raw pins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef GPIO_BANK_DEBOUNCE_EN
    logic [PRESC_BITS-1:0] presc_q;
    logic                  tick_c;

    assign tick_c = &presc_q;

    // Free-running prescaler shared by every debounce instance.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRESC_BITS'(1);
        end
    end

    for (genvar i = 0; i < int'(IN_WIDTH); i++) begin : g_db
        gpio_debounce #(.DB_TAPS(DB_TAPS)) u_db (
            .clk  (clk),
            .rstn (rstn),
            .tick (tick_c),
            .din  (sync2_q[i]),
            .filt (filt[i])
        );
    end
`else
    // Unfiltered path: one register stage after the synchroniser.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            filt <= '0;
        end else begin
            filt <= sync2_q;
        end
    end
`endif

    // Previous filtered level for edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_q <= '0;
        end else begin
            prev_q <= filt;
        end
    end

    assign rise_c   = filt & ~prev_q;
    assign fall_c   = ~filt & prev_q;
    assign ip_set_c = (rise_c & rise_en_q) | (fall_c & fall_en_q);
    assign ip_clr_c = (en && req_c.addr == REG_IP) ?
                      IN_WIDTH'(req_c.data & lane_mask(req_c.be)) : '0;

    // Register writes, pending-bit update (set beats clear) and irq.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gpio_out  <= '0;
            ie_q      <= '0;
            ip_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            ctrl_q    <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (en && req_c.addr == REG_OUT)
                gpio_out <= OUT_WIDTH'(merge_bytes(BUS_W'(gpio_out), req_c.data, req_c.be));
            if (en && req_c.addr == REG_IE)
                ie_q <= IN_WIDTH'(merge_bytes(BUS_W'(ie_q), req_c.data, req_c.be));
            if (en && req_c.addr == REG_RISE)
                rise_en_q <= IN_WIDTH'(merge_bytes(BUS_W'(rise_en_q), req_c.data, req_c.be));
            if (en && req_c.addr == REG_FALL)
                fall_en_q <= IN_WIDTH'(merge_bytes(BUS_W'(fall_en_q), req_c.data, req_c.be));
            if (en && req_c.addr == REG_CTRL && req_c.be[0])
                ctrl_q <= req_c.data[CTRL_IRQ_EN_BIT];
            ip_q <= (ip_q & ~ip_clr_c) | ip_set_c;
            irq  <= ctrl_q & |(ip_q & ie_q);
        end
    end

    // Read mux over current (pre-write) register values.
    always_comb begin
        rdata_c = '0;
        case (req_c.addr)
            REG_IN:   rdata_c = BUS_W'(filt);
            REG_OUT:  rdata_c = BUS_W'(gpio_out);
            REG_IE:   rdata_c = BUS_W'(ie_q);
            REG_IP:   rdata_c = BUS_W'(ip_q);
            REG_RISE: rdata_c = BUS_W'(rise_en_q);
            REG_FALL: rdata_c = BUS_W'(fall_en_q);
            REG_CTRL: rdata_c[CTRL_IRQ_EN_BIT] = ctrl_q;
            default:  rdata_c = '0;
        endcase
    end

    // Registered read data, held while the bank is not selected.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout <= '0;
        end else if (en) begin
            dout <= rdata_c;
        end
    end

endmodule
